// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Buffered request/response front end for the combinational ALU.
// Requests are accepted on a valid/ready port and queued in a DEPTH-entry
// FIFO. The FIFO head drives the ALU operand, opcode and shift-amount ports
// directly. When the response register is free, or is being drained in the
// same cycle, the ALU result and flags are captured into it. The head entry
// is then popped, and the capture is stamped with a sequence tag.
//
// Parameters
//   DEPTH            request FIFO entries (power of 2, >= 2)
//
// Ports
//   clock            sole clock, rising edge
//   reset            asynchronous, active-low; clears all state
//   req_valid/ready  request handshake (req_ready = !full)
//   req_opA/opB      32-bit operands
//   req_opcode       5-bit ALU opcode, passed through undecoded
//   req_shamt        5-bit shift amount
//   alu_operandA/B   FIFO head operands to the ALU (0 when empty)
//   alu_opcode       FIFO head opcode to the ALU (0 when empty)
//   alu_shiftamt     FIFO head shift amount to the ALU (0 when empty)
//   alu_result       combinational ALU result
//   alu_isNotEqual   combinational ALU flag
//   alu_isLessThan   combinational ALU flag
//   alu_overflow     combinational ALU flag
//   rsp_valid/ready  response handshake
//   rsp_result       captured ALU result
//   rsp_is*/overflow captured ALU flags
//   rsp_tag          sequence number of the current response
//   ovf_count        saturating count of captures with overflow=1
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,

    // Request port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_opA,
    input  logic [31:0] req_opB,
    input  logic [4:0]  req_opcode,
    input  logic [4:0]  req_shamt,

    // ALU drive (from FIFO head)
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,

    // ALU return (combinational)
    input  logic [31:0] alu_result,
    input  logic        alu_isNotEqual,
    input  logic        alu_isLessThan,
    input  logic        alu_overflow,

    // Response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_isNotEqual,
    output logic        rsp_isLessThan,
    output logic        rsp_overflow,
    output logic [7:0]  rsp_tag,
    output logic [15:0] ovf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  opcode;
        logic [4:0]  shamt;
    } req_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    req_t              r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_rsp_valid;
    logic [31:0]       r_rsp_result;
    logic              r_rsp_ne;
    logic              r_rsp_lt;
    logic              r_rsp_ovf;
    logic [7:0]        r_rsp_tag;
    logic [7:0]        r_tag_cnt;
    logic [15:0]       r_ovf_count;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_capture;
    logic [CNT_W-1:0]  w_count_nxt;
    req_t              w_head;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // req_ready depends only on registered occupancy. A pop in the same
    // cycle does not free a slot for a push into a full FIFO, which keeps
    // rsp_ready off the req_ready path.
    assign w_push = req_valid && !w_full;

    // The response register can take a new value when it is empty, or when
    // its current value leaves in this same cycle.
    assign w_capture = !w_empty && (!r_rsp_valid || rsp_ready);

    assign w_head = r_mem[r_rd_ptr];

    // Occupancy: a simultaneous push and pop leave the count unchanged.
    // NOTE: every signal assigned in always_comb receives a default first, so no latch can be inferred.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_capture})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Entries are only visible through the head when the count says they are valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{op_a:   req_opA,
                                 op_b:   req_opB,
                                 opcode: req_opcode,
                                 shamt:  req_shamt};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_capture) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Response register, tag counter and overflow counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_ne     <= 1'b0;
            r_rsp_lt     <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_tag    <= '0;
            r_tag_cnt    <= '0;
            r_ovf_count  <= '0;
        end else begin
            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= alu_result;
                r_rsp_ne     <= alu_isNotEqual;
                r_rsp_lt     <= alu_isLessThan;
                r_rsp_ovf    <= alu_overflow;
                r_rsp_tag    <= r_tag_cnt;
                r_tag_cnt    <= r_tag_cnt + 8'd1;
                if (alu_overflow && (r_ovf_count != 16'hFFFF)) begin
                    r_ovf_count <= r_ovf_count + 16'd1;
                end
            end else if (r_rsp_valid && rsp_ready) begin
                // Consumed without a replacement. The data fields keep their
                // last value.
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready = !w_full;

    // The ALU sees zeros while the FIFO is empty. This avoids exposing stale
    // storage and gives clean values after reset.
    assign alu_operandA = w_empty ? 32'd0 : w_head.op_a;
    assign alu_operandB = w_empty ? 32'd0 : w_head.op_b;
    assign alu_opcode   = w_empty ? 5'd0  : w_head.opcode;
    assign alu_shiftamt = w_empty ? 5'd0  : w_head.shamt;

    assign rsp_valid      = r_rsp_valid;
    assign rsp_result     = r_rsp_result;
    assign rsp_isNotEqual = r_rsp_ne;
    assign rsp_isLessThan = r_rsp_lt;
    assign rsp_overflow   = r_rsp_ovf;
    assign rsp_tag        = r_rsp_tag;
    assign ovf_count      = r_ovf_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. A small reference ALU (add, sub,
// and) answers the DUT's combinational ALU port. Every accepted request
// pushes its expected response into a scoreboard queue. Each consumed
// response pops the queue and is compared. Directed checks cover reset,
// latency, flags, backpressure, overflow counting, tag wrap and mid-stream
// reset.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_opA = '0;
    logic [31:0] req_opB = '0;
    logic [4:0]  req_opcode = '0;
    logic [4:0]  req_shamt = '0;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shiftamt;
    logic [31:0] alu_result;
    logic        alu_isNotEqual;
    logic        alu_isLessThan;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_isNotEqual;
    logic        rsp_isLessThan;
    logic        rsp_overflow;
    logic [7:0]  rsp_tag;
    logic [15:0] ovf_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opA        (req_opA),
        .req_opB        (req_opB),
        .req_opcode     (req_opcode),
        .req_shamt      (req_shamt),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shiftamt   (alu_shiftamt),
        .alu_result     (alu_result),
        .alu_isNotEqual (alu_isNotEqual),
        .alu_isLessThan (alu_isLessThan),
        .alu_overflow   (alu_overflow),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_isNotEqual (rsp_isNotEqual),
        .rsp_isLessThan (rsp_isLessThan),
        .rsp_overflow   (rsp_overflow),
        .rsp_tag        (rsp_tag),
        .ovf_count      (ovf_count)
    );

    // -------------------------------------------------------------------------
    // Reference ALU: opcode 0 = add, 1 = sub, anything else = and
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] result;
        logic        ne;
        logic        lt;
        logic        ovf;
    } alu_out_t;

    function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op);
        alu_out_t o;
        logic [31:0] sum;
        logic [31:0] dif;
        sum = a + b;
        dif = a - b;
        o.ne = (a != b);
        o.lt = ($signed(a) < $signed(b));
        case (op)
            5'd0: begin
                o.result = sum;
                o.ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            5'd1: begin
                o.result = dif;
                o.ovf    = (a[31] != b[31]) && (dif[31] != a[31]);
            end
            default: begin
                o.result = a & b;
                o.ovf    = 1'b0;
            end
        endcase
        return o;
    endfunction

    alu_out_t alu_now;
    assign alu_now        = alu_ref(alu_operandA, alu_operandB, alu_opcode);
    assign alu_result     = alu_now.result;
    assign alu_isNotEqual = alu_now.ne;
    assign alu_isLessThan = alu_now.lt;
    assign alu_overflow   = alu_now.ovf;

    // -------------------------------------------------------------------------
    // Comparison helper
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard and monitor (samples on the falling edge)
    // -------------------------------------------------------------------------
    typedef struct packed {
        alu_out_t    alu;
        logic [7:0]  tag;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  exp_tag   = '0;
    logic [15:0] model_ovf = '0;
    int          n_rsp     = 0;
    logic [7:0]  last_tag  = '0;

    always @(negedge clock) begin
        if (reset) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_unexpected: observed tag=%0d expected no response", rsp_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.alu.ovf && model_ovf != 16'hFFFF) model_ovf = model_ovf + 16'd1;
                    check("sb_result", rsp_result, e.alu.result);
                    check("sb_ne", 32'(rsp_isNotEqual), 32'(e.alu.ne));
                    check("sb_lt", 32'(rsp_isLessThan), 32'(e.alu.lt));
                    check("sb_ovf", 32'(rsp_overflow), 32'(e.alu.ovf));
                    check("sb_tag", 32'(rsp_tag), 32'(e.tag));
                    check("sb_ovf_count", 32'(ovf_count), 32'(model_ovf));
                    n_rsp++;
                    last_tag = rsp_tag;
                end
            end
            if (req_valid && req_ready) begin
                exp_t n;
                n.alu = alu_ref(req_opA, req_opB, req_opcode);
                n.tag = exp_tag;
                sb.push_back(n);
                exp_tag = exp_tag + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic clear_model();
        sb.delete();
        exp_tag   = '0;
        model_ovf = '0;
        n_rsp     = 0;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        reset     = 1'b0;
        clear_model();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Presents one request and returns 1 time unit after the edge that
    // accepted it.
    task automatic push_one(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] op, input logic [4:0] sh);
        int n;
        req_valid  = 1'b1;
        req_opA    = a;
        req_opB    = b;
        req_opcode = op;
        req_shamt  = sh;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $error("FAIL push_timeout: observed req_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int accepted;
        int n;

        // Reset state
        do_reset();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_alu_opA", alu_operandA, 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);

        // Add: head visible next cycle, response two cycles after push
        rsp_ready = 1'b1;
        push_one(32'd3, 32'd1, 5'd0, 5'd7);
        check("add_head_opA", alu_operandA, 32'd3);
        check("add_head_shamt", 32'(alu_shiftamt), 32'd7);
        check("add_not_yet_valid", 32'(rsp_valid), 32'd0);
        @(posedge clock);
        #1;
        check("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_rsp_result", rsp_result, 32'd4);
        check("add_rsp_tag", 32'(rsp_tag), 32'd0);
        repeat (2) @(posedge clock);
        #1;

        // Subtract with flags, back to back
        do_reset();
        rsp_ready = 1'b1;
        push_one(32'd3, 32'd1, 5'd1, 5'd0);
        push_one(32'd1, 32'd3, 5'd1, 5'd0);
        check("sub1_result", rsp_result, 32'd2);
        check("sub1_ne", 32'(rsp_isNotEqual), 32'd1);
        check("sub1_lt", 32'(rsp_isLessThan), 32'd0);
        check("sub1_tag", 32'(rsp_tag), 32'd0);
        @(posedge clock);
        #1;
        check("sub2_valid", 32'(rsp_valid), 32'd1);
        check("sub2_result", rsp_result, 32'hFFFF_FFFE);
        check("sub2_lt", 32'(rsp_isLessThan), 32'd1);
        check("sub2_tag", 32'(rsp_tag), 32'd1);
        repeat (2) @(posedge clock);
        #1;

        // Backpressure: six offered, five accepted
        do_reset();
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid  = 1'b1;
            req_opA    = 32'(i * 10);
            req_opB    = 32'(i);
            req_opcode = 5'd0;
            req_shamt  = 5'd0;
            if (req_ready) accepted++;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_req_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_valid", 32'(rsp_valid), 32'd1);
            check("bp_drain_tag", 32'(rsp_tag), 32'(i));
            @(posedge clock);
            #1;
        end
        check("bp_drained_valid", 32'(rsp_valid), 32'd0);
        check("bp_req_ready_back", 32'(req_ready), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Overflow counting
        do_reset();
        rsp_ready = 1'b1;
        push_one(32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
        push_one(32'd1, 32'd1, 5'd0, 5'd0);
        check("ovf_flag", 32'(rsp_overflow), 32'd1);
        check("ovf_result", rsp_result, 32'h8000_0000);
        check("ovf_count_1", 32'(ovf_count), 32'd1);
        @(posedge clock);
        #1;
        check("ovf_clear_flag", 32'(rsp_overflow), 32'd0);
        check("ovf_clear_result", rsp_result, 32'd2);
        check("ovf_count_hold", 32'(ovf_count), 32'd1);
        repeat (2) @(posedge clock);
        #1;

        // Tag wrap over 257 responses
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push_one(32'(i), 32'd1, 5'd0, 5'd0);
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);
        check("wrap_rsp_count", 32'(n_rsp), 32'd257);
        check("wrap_last_tag", 32'(last_tag), 32'd0);

        // Reset mid-stream with three queued and a pending response
        do_reset();
        rsp_ready = 1'b0;
        push_one(32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
        push_one(32'd5, 32'd1, 5'd0, 5'd0);
        push_one(32'd6, 32'd1, 5'd0, 5'd0);
        push_one(32'd7, 32'd1, 5'd0, 5'd0);
        check("mid_pre_valid", 32'(rsp_valid), 32'd1);
        check("mid_pre_ovf_count", 32'(ovf_count), 32'd1);
        check("mid_pre_head", alu_operandA, 32'd5);
        reset = 1'b0;
        clear_model();
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_req_ready", 32'(req_ready), 32'd1);
        check("mid_alu_opA", alu_operandA, 32'd0);
        check("mid_alu_opB", alu_operandB, 32'd0);
        check("mid_ovf_count", 32'(ovf_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        push_one(32'd5, 32'd6, 5'd0, 5'd0);
        @(posedge clock);
        #1;
        check("post_rst_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_tag", 32'(rsp_tag), 32'd0);
        check("post_rst_result", rsp_result, 32'd11);
        repeat (2) @(posedge clock);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Buffered request/response front end for the team's combinational `alu`: accepts operation requests on a valid/ready port, queues them in a DEPTH-entry FIFO, and drives the ALU operand, opcode and shift ports from the FIFO head. It registers the ALU result and flags into a response register with a valid/ready port, a sequence tag and a saturating overflow counter. It is the requesting end of the ALU interface and replaces ad-hoc direct drive of the ALU ports by the processor and bench harnesses.

## Interface
- DEPTH, 4, request FIFO entries; power of 2, at least 2
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept; equals !full
- req_opA  in  32  operand A
- req_opB  in  32  operand B
- req_opcode  in  5  ALU opcode, passed through undecoded
- req_shamt  in  5  shift amount
- alu_operandA  out  32  FIFO head opA; 0 when FIFO empty
- alu_operandB  out  32  FIFO head opB; 0 when empty
- alu_opcode  out  5  FIFO head opcode; 0 when empty
- alu_shiftamt  out  5  FIFO head shamt; 0 when empty
- alu_result  in  32  combinational ALU result
- alu_isNotEqual, alu_isLessThan, alu_overflow  in  1 each  combinational ALU flags
- rsp_valid  out  1  response register holds an unconsumed result
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_isNotEqual, rsp_isLessThan, rsp_overflow  out  1 each  captured flags
- rsp_tag  out  8  sequence number of the current response
- ovf_count  out  16  saturating count of captured results with overflow=1

## Operation
- Push: when req_valid && req_ready, write {opA, opB, opcode, shamt} at the write pointer; the pointer wraps modulo DEPTH.
- Occupancy counter runs 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- The ALU ports are driven combinationally from the head entry; the block does not register the ALU outputs before capture.
- Capture condition: !empty && (!rsp_valid || rsp_ready). On capture:
  - load rsp_result and the three flags from the ALU;
  - pop the head and set rsp_valid=1;
  - rsp_tag takes the value of the internal tag counter, which then increments (8-bit wrap, 255 -> 0);
  - if alu_overflow=1, increment ovf_count, which holds at 0xFFFF.
- Response consume: when rsp_valid && rsp_ready and there is no capture in the same cycle, clear rsp_valid. The rsp_* data holds its last value.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into an empty FIFO is not visible at the head until the next cycle.
- There is no combinational path from rsp_ready to req_ready.

## Timing
- Reset values:
  - all rsp_* outputs, rsp_tag, ovf_count, the tag counter, pointers and count are 0;
  - alu_* outputs are 0;
  - req_ready=1 once reset is released.
- Reset asserted mid-operation discards FIFO contents and any pending response immediately and asynchronously.
- Latency: a request accepted at edge N is at the head during cycle N+1, is captured at edge N+1, and shows rsp_valid=1 in cycle N+2. Minimum latency is 2 cycles.
- Throughput: 1 response per cycle while rsp_ready=1 and the FIFO is non-empty.
- Backpressure: with rsp_ready held low, the block accepts at most DEPTH+1 requests: one in the response register and DEPTH in the FIFO.

## Test plan
- Add: reset, push opA=3, opB=1, opcode=00000 -> alu_operandA=3 in the next cycle; rsp_valid=1 two cycles after push with rsp_result=4, rsp_tag=0.
- Subtract plus flags: push 3, 1, opcode=00001, then 1, 3, opcode=00001 back-to-back with rsp_ready=1 -> the first response is rsp_result=2, isNotEqual=1, isLessThan=0, tag 0. The second follows in the next cycle with result 0xFFFFFFFE, isLessThan=1, tag 1.
- Backpressure: rsp_ready=0, push 6 requests -> 5 accepted, req_ready=0 after the fifth. Raise rsp_ready -> tags 0..4 drain in order, one per cycle, and req_ready returns to 1.
- Overflow: push 0x7FFFFFFF + 1 with opcode=00000 -> rsp_overflow=1, rsp_result=0x80000000, ovf_count=1. A following non-overflowing add leaves ovf_count=1.
- Tag wrap: stream 257 adds -> the 256th response has tag 255 and the 257th has tag 0.
- Reset mid-stream: with 3 queued and rsp_valid=1, drive reset low -> rsp_valid=0, req_ready=1, alu_* outputs=0 and ovf_count=0 immediately. After release, a new push returns tag 0.
